// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULT/DIV support).
package muldiv_pkg;

    // FSM states; busy is RUN, done is DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Value of the mul0_div1_sel input for each operation.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Quotient reported for a zero divisor; sliced to the operand width by users.
    localparam int                    DIV0_MAX_W = 64;
    localparam logic [DIV0_MAX_W-1:0] DIV0_QUOT  = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Signed operand/result conditioning for muldiv_unit (built only with MULDIV_SIGNED_EN).
// Operands become magnitudes before the unsigned core runs; the raw unsigned
// result is negated as needed at the DONE load so latency does not change.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] mag_a_o,
    output logic [WIDTH-1:0] mag_b_o,
    output logic             neg_res_o,
    output logic             neg_rem_o,
    input  logic             op_sel_i,
    input  logic             neg_res_i,
    input  logic             neg_rem_i,
    input  logic [WIDTH-1:0] raw_hi_i,
    input  logic [WIDTH-1:0] raw_lo_i,
    output logic [WIDTH-1:0] fix_hi_o,
    output logic [WIDTH-1:0] fix_lo_o
);

    logic               a_neg;
    logic               b_neg;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg     = signed_op_i & op_a_i[WIDTH-1];
    assign b_neg     = signed_op_i & op_b_i[WIDTH-1];
    assign mag_a_o   = a_neg ? -op_a_i : op_a_i;
    assign mag_b_o   = b_neg ? -op_b_i : op_b_i;
    // Product and quotient flip on differing signs; remainder follows the dividend.
    assign neg_res_o = a_neg ^ b_neg;
    assign neg_rem_o = a_neg;

    assign prod      = {raw_hi_i, raw_lo_i};
    assign prod_neg  = -prod;

    // Apply the latched sign corrections to the unsigned result.
    always_comb begin
        fix_hi_o = raw_hi_i;
        fix_lo_o = raw_lo_i;
        if (op_sel_i == OP_MUL) begin
            if (neg_res_i) begin
                fix_hi_o = prod_neg[2*WIDTH-1:WIDTH];
                fix_lo_o = prod_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_res_i) fix_lo_o = -raw_lo_i;
            if (neg_rem_i) fix_hi_o = -raw_hi_i;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULTU/DIVU unit with HI/LO registers for the MIPS32 execute stage.
// One iteration per clock: shift-add multiply, restoring divide.
// Optional feature macro: MULDIV_SIGNED_EN adds MULT/DIV via muldiv_sign_fix.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mul0_div1_sel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               last_iter;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   src_a, src_b;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [WIDTH-1:0]   load_lo;

`ifdef MULDIV_SIGNED_EN
    logic neg_res_q, neg_rem_q;
    logic neg_res_in, neg_rem_in;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op_i (signed_op),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .mag_a_o     (src_a),
        .mag_b_o     (src_b),
        .neg_res_o   (neg_res_in),
        .neg_rem_o   (neg_rem_in),
        .op_sel_i    (op_q),
        .neg_res_i   (neg_res_q),
        .neg_rem_i   (neg_rem_q),
        .raw_hi_i    (acc_d[2*WIDTH-1:WIDTH]),
        .raw_lo_i    (acc_d[WIDTH-1:0]),
        .fix_hi_o    (res_hi),
        .fix_lo_o    (res_lo)
    );

    // Sign flags captured with the operands at the start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            neg_res_q <= neg_res_in;
            neg_rem_q <= neg_rem_in;
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign src_a            = op_a;
    assign src_b            = op_b;
    assign res_hi           = acc_d[2*WIDTH-1:WIDTH];
    assign res_lo           = acc_d[WIDTH-1:0];
`endif

    assign last_iter = (cnt_q == CNT_W'(1));
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // A zero divisor always reports an all-ones quotient, regardless of sign fix-up.
    assign load_lo = (op_q == OP_DIV && opnd_q == '0) ? DIV0_QUOT[WIDTH-1:0] : res_lo;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: start only honoured in IDLE, DONE always returns to IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        acc_d     = acc_q;
        add_sum   = '0;
        rem_shift = '0;
        rem_diff  = '0;
        if (op_q == OP_MUL) begin
            add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
            acc_d   = {add_sum, acc_q[WIDTH-1:1]};
        end else begin
            rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            rem_diff  = rem_shift - {1'b0, opnd_q};
            if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                  acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture, iteration counter, working registers and HI/LO load.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: working registers are reset too, so an abandoned operation leaves no residue.
        if (!rst) begin
            cnt_q  <= '0;
            op_q   <= OP_MUL;
            acc_q  <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q  <= CNT_W'(WIDTH);
                        op_q   <= mul0_div1_sel;
                        acc_q  <= (mul0_div1_sel == OP_MUL) ? {{WIDTH{1'b0}}, src_b}
                                                            : {{WIDTH{1'b0}}, src_a};
                        opnd_q <= (mul0_div1_sel == OP_MUL) ? src_a : src_b;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    acc_q <= acc_d;
                    if (last_iter) begin
                        hi_q <= res_hi;
                        lo_q <= load_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage of the pipelined MIPS32 core. It implements MULTU and DIVU, and MULT/DIV when the optional feature is compiled in. Results go to architectural HI/LO registers that MFHI/MFLO read. The hazard unit stalls F/D/E on busy, and the decoder's qualified mul/div enable drives start.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
start  in  1  request a new operation; sampled only in IDLE
mul0_div1_sel  in  1  0 = multiply, 1 = divide
signed_op  in  1  1 = signed op; ignored unless MULDIV_SIGNED_EN
op_a  in  WIDTH  multiplicand / dividend (rs)
op_b  in  WIDTH  multiplier / divisor (rt)
hi  out  WIDTH  HI register: product[2W-1:W] or remainder
lo  out  WIDTH  LO register: product[W-1:0] or quotient
busy  out  1  operation in progress; hazard unit stalls on it
done  out  1  one-cycle pulse; hi/lo updated this cycle

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared. An operation in progress is abandoned and no done pulse is produced.
- States and outputs: IDLE, RUN, DONE. busy=(state==RUN). done=(state==DONE).
- IDLE: start=1 at edge k → latch op_a, op_b, mul0_div1_sel, signed_op; counter=WIDTH; go to RUN.
- RUN: one iteration per edge, at edges k+1 through k+WIDTH; counter decrements each edge.
  - Multiply: shift-add over a 2W-bit accumulator.
  - Divide: restoring division with a W+1-bit partial remainder.
  - At the edge where the counter reaches 0 (edge k+WIDTH): load hi/lo and go to DONE.
- DONE: lasts one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency: start at edge k → done high, with new hi/lo valid, in the cycle after edge k+WIDTH (32 edges for WIDTH=32). busy is high for WIDTH cycles.
- hi/lo hold their previous values throughout RUN and change only on the DONE load or reset. MFHI/MFLO issued during RUN is stalled by the hazard unit, not by this block.
- start while RUN or DONE: ignored, no queuing. Operand changes after the start edge have no effect.
- Divide by zero (op_b==0): lo=all ones, hi=op_a. The full WIDTH iterations still run, so latency is fixed.
- Arithmetic: product is the exact 2W-bit result. Quotient truncates toward zero; remainder satisfies a = q*b + r.
- Without MULDIV_SIGNED_EN, all operations are unsigned.

Optional Feature:
MULDIV_SIGNED_EN.
- Defined: when signed_op=1, operands are converted to magnitudes at the start edge and the iterative core runs unsigned. Sign fix-up is applied combinationally at the DONE load, so latency is unchanged.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Signed divide by zero gives lo=all ones, hi=op_a.
  - Overflow case (most-negative / -1): lo=most-negative, hi=0.
- Undefined: signed_op is ignored and no negation logic is synthesised.

Decomposition:
- Package muldiv_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_DONE;
  - opcode select constants OP_MUL=0, OP_DIV=1;
  - DIV0_QUOT = all ones.
- Sub-module muldiv_sign_fix is natural: combinational magnitude/negate logic, instantiated only under MULDIV_SIGNED_EN.
- FSM, counter and datapath stay in muldiv_unit.

Test Plan:
- Unsigned multiply: multiply, op_a=op_b=0xFFFFFFFF, start 1 cycle → busy for 32 cycles, done after edge k+32, hi=0xFFFFFFFE, lo=0x00000001.
- Unsigned divide: divide, 100/7 → lo=14, hi=2 with the same latency. Then 5/9 → lo=0, hi=5.
- Divide by zero: divide, 0x1234/0 → lo=0xFFFFFFFF, hi=0x00001234, done after edge k+32.
- Start while busy: multiply 3*4 started; at cycle 5 start=1 with divide 8/2 → ignored; single done with hi=0, lo=12.
- Reset mid-operation: rst=0 at cycle 10 of a multiply → busy=0, hi=lo=0, no done pulse. A new 6*7 after reset release → lo=42.
- MULDIV_SIGNED_EN:
  - signed divide -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - signed multiply -3*5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1;
  - 0x80000000/-1 → lo=0x80000000, hi=0.
